// File: rtl/multi_biterr_counter.sv
// Multi-channel gated bit-error counter: per-channel counts over a shared interval,
// snapshotted together at the terminal cycle, with registered channel-select readout.
module multi_biterr_counter #(
  parameter int unsigned NCH            = 8,
  parameter int unsigned CNT_WIDTH      = 25,
  parameter int unsigned INTERVAL_WIDTH = 24,
  parameter string       MODE           = "FREE",
  localparam int unsigned SEL_WIDTH     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NCH-1:0]            err_i,
  input  logic [INTERVAL_WIDTH-1:0] interval_i,
  input  logic                      interval_load_i,
  input  logic [SEL_WIDTH-1:0]      sel_i,
  output logic [CNT_WIDTH-1:0]      count_o,
  output logic                      sat_o,
  output logic                      valid_o,
  input  logic                      ack_i
);

  localparam bit                   ACK_MODE = (MODE == "ACKNOWLEDGE");
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [INTERVAL_WIDTH-1:0] interval_q;
  logic [INTERVAL_WIDTH-1:0] timer_q, timer_d;
  logic                      valid_d;
  logic                      cnt_clr_c, cnt_en_c, snap_en_c, tc_c;

  logic [CNT_WIDTH-1:0] cnt_q     [NCH];
  logic [CNT_WIDTH-1:0] cnt_inc_c [NCH];
  logic [CNT_WIDTH-1:0] snap_q    [NCH];
  logic [NCH-1:0]       sat_q;
  logic [CNT_WIDTH-1:0] rd_cnt_c;
  logic                 rd_sat_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Gate control: a load overrides every other event, including tc and ack
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    cnt_clr_c = 1'b0;
    cnt_en_c  = 1'b0;
    snap_en_c = 1'b0;
    valid_d   = 1'b0;
    tc_c      = (state_q == ST_RUN) && (timer_q == interval_q - INTERVAL_WIDTH'(1));
    if (interval_load_i) begin
      state_d   = (interval_i == '0) ? ST_IDLE : ST_RUN;
      timer_d   = '0;
      cnt_clr_c = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          timer_d = '0;
        end
        ST_RUN: begin
          if (tc_c) begin
            timer_d   = '0;
            cnt_clr_c = 1'b1;
            snap_en_c = 1'b1;
            valid_d   = 1'b1;
            if (ACK_MODE) state_d = ST_HOLD;
          end else begin
            timer_d  = timer_q + INTERVAL_WIDTH'(1);
            cnt_en_c = 1'b1;
          end
        end
        ST_HOLD: begin
          if (ack_i) begin
            state_d = ST_RUN;
          end else begin
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      endcase
    end
  end

  // Saturating increment per channel
  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) begin
      cnt_inc_c[i] = (cnt_q[i] == CNT_MAX) ? cnt_q[i] : cnt_q[i] + CNT_WIDTH'(err_i[i]);
    end
  end

  // Readout mux; selects beyond the last channel read as zero
  always_comb begin
    rd_cnt_c = '0;
    rd_sat_c = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (sel_i == SEL_WIDTH'(i)) begin
        rd_cnt_c = snap_q[i];
        rd_sat_c = sat_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interval_q <= '0;
      timer_q    <= '0;
      valid_o    <= 1'b0;
      count_o    <= '0;
      sat_o      <= 1'b0;
      sat_q      <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      if (interval_load_i) interval_q <= interval_i;
      timer_q <= timer_d;
      valid_o <= valid_d;
      count_o <= rd_cnt_c;
      sat_o   <= rd_sat_c;
      for (int unsigned i = 0; i < NCH; i++) begin
        if (cnt_clr_c) begin
          cnt_q[i] <= '0;
        end else if (cnt_en_c) begin
          cnt_q[i] <= cnt_inc_c[i];
        end
        if (snap_en_c) begin
          snap_q[i] <= cnt_inc_c[i];
          sat_q[i]  <= (cnt_inc_c[i] == CNT_MAX);
        end
      end
    end
  end

endmodule
